// File: rtl/class_hvec_seq.sv
// class_hvec_seq: sweeps every enabled class and each of its frames, addressing the
// combinational class hypervector ROM and streaming each returned chunk downstream.
// Ports: clk/rst_n (async active-low); start/abort/cfg_class_mask control a sweep;
// busy/done report status; rom_frame_id/rom_frame_index address the ROM and rom_data
// returns the chunk; m_valid/m_ready/m_data plus the m_* tags form the output stream.
module class_hvec_seq #(
  parameter int DI_PARALLEL_W_BITS = 64,
  parameter int N_CLASSES          = 8,
  parameter int N_FRAMES           = 3,
  parameter int CLASS_ID_W         = 3,
  parameter int FRAME_IDX_W        = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic                          abort,
  input  logic [N_CLASSES-1:0]          cfg_class_mask,
  output logic                          busy,
  output logic                          done,
  output logic [CLASS_ID_W-1:0]         rom_frame_id,
  output logic [FRAME_IDX_W-1:0]        rom_frame_index,
  input  logic [DI_PARALLEL_W_BITS-1:0] rom_data,
  output logic                          m_valid,
  input  logic                          m_ready,
  output logic [DI_PARALLEL_W_BITS-1:0] m_data,
  output logic [CLASS_ID_W-1:0]         m_class_id,
  output logic [FRAME_IDX_W-1:0]        m_frame_index,
  output logic                          m_last_frame,
  output logic                          m_last
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t                 state;
  logic [N_CLASSES-1:0]   mask;
  logic [CLASS_ID_W-1:0]  first_cls;   // lowest set bit of the incoming mask
  logic [CLASS_ID_W-1:0]  last_cls;    // highest set bit of the latched mask
  logic [CLASS_ID_W-1:0]  next_cls;    // next set bit above the current class
  logic                   frm_last;
  logic                   is_final;
  logic                   load;

  // The ROM address registers double as the sweep position (cls/frm).
  always_comb begin
    first_cls = '0;
    for (int i = N_CLASSES - 1; i >= 0; i--) begin
      if (cfg_class_mask[i]) first_cls = CLASS_ID_W'(i);
    end
    last_cls = '0;
    for (int i = 0; i < N_CLASSES; i++) begin
      if (mask[i]) last_cls = CLASS_ID_W'(i);
    end
    next_cls = rom_frame_id;
    for (int i = N_CLASSES - 1; i >= 0; i--) begin
      if (mask[i] && (i > int'(rom_frame_id))) next_cls = CLASS_ID_W'(i);
    end
  end

  assign frm_last     = (rom_frame_index == FRAME_IDX_W'(N_FRAMES - 1));
  assign is_final     = frm_last && (rom_frame_id == last_cls);
  // Output register can take a new chunk when empty or being drained this cycle.
  assign load         = !m_valid || m_ready;
  assign m_last_frame = (m_frame_index == FRAME_IDX_W'(N_FRAMES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      mask            <= '0;
      busy            <= 1'b0;
      done            <= 1'b0;
      rom_frame_id    <= '0;
      rom_frame_index <= '0;
      m_valid         <= 1'b0;
      m_data          <= '0;
      m_class_id      <= '0;
      m_frame_index   <= '0;
      m_last          <= 1'b0;
    end else begin
      done <= 1'b0;
      if (abort) begin
        // Cancel drops any pending beat without a done pulse; abort beats start.
        state   <= IDLE;
        m_valid <= 1'b0;
        busy    <= 1'b0;
        m_last  <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              mask <= cfg_class_mask;
              if (cfg_class_mask == '0) begin
                done <= 1'b1;
              end else begin
                rom_frame_id    <= first_cls;
                rom_frame_index <= '0;
                busy            <= 1'b1;
                state           <= RUN;
              end
            end
          end
          RUN: begin
            if (load) begin
              m_data        <= rom_data;
              m_class_id    <= rom_frame_id;
              m_frame_index <= rom_frame_index;
              m_valid       <= 1'b1;
              m_last        <= is_final;
              if (is_final) begin
                // Address holds on the final element so it stays in range.
                state <= DRAIN;
              end else if (frm_last) begin
                rom_frame_index <= '0;
                rom_frame_id    <= next_cls;
              end else begin
                rom_frame_index <= rom_frame_index + 1'b1;
              end
            end
          end
          DRAIN: begin
            if (m_valid && m_ready) begin
              m_valid <= 1'b0;
              m_last  <= 1'b0;
              busy    <= 1'b0;
              done    <= 1'b1;
              state   <= IDLE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_class_hvec_seq.sv
// tb_class_hvec_seq: directed bench for class_hvec_seq with a behavioural ROM that
// answers the two hand-specified addresses with their known chunks.
module tb_class_hvec_seq;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        abort;
  logic [7:0]  cfg_class_mask;
  logic        busy;
  logic        done;
  logic [2:0]  rom_frame_id;
  logic [1:0]  rom_frame_index;
  logic [63:0] rom_data;
  logic        m_valid;
  logic        m_ready;
  logic [63:0] m_data;
  logic [2:0]  m_class_id;
  logic [1:0]  m_frame_index;
  logic        m_last_frame;
  logic        m_last;

  int errors = 0;
  int checks = 0;

  class_hvec_seq #(
    .DI_PARALLEL_W_BITS(64), .N_CLASSES(8), .N_FRAMES(3), .CLASS_ID_W(3), .FRAME_IDX_W(2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .cfg_class_mask(cfg_class_mask),
    .busy(busy), .done(done), .rom_frame_id(rom_frame_id), .rom_frame_index(rom_frame_index),
    .rom_data(rom_data), .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .m_class_id(m_class_id), .m_frame_index(m_frame_index), .m_last_frame(m_last_frame),
    .m_last(m_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] rom_f(input logic [2:0] id, input logic [1:0] idx);
    if (id == 3'd0 && idx == 2'd0) return 64'h0003_007C_FE70_218C;
    if (id == 3'd7 && idx == 2'd2) return 64'h9FF1_8781_E7FC_E0FF;
    return {16'hC1A5, 13'd0, id, 14'd0, idx, 16'hBEEF};
  endfunction

  always_comb rom_data = rom_f(rom_frame_id, rom_frame_index);

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [7:0] msk);
    start = 1'b1;
    cfg_class_mask = msk;
    step();
    start = 1'b0;
  endtask

  // Runs one sweep from the sample point just after the accepted start edge.
  // stall selects the 1,0,0,1 ready pattern; abort_after>=0 aborts after that many
  // handshakes; restart_at>=0 pulses an extra start; exp_busy>=0 checks busy length.
  task automatic run(input logic [7:0] msk, input int stall, input int abort_after,
                     input int restart_at, input int exp_busy);
    int ec[24];
    int ef[24];
    int total = 0;
    int k = 0;
    int busy_cnt = 0;
    int ab = 0;
    bit fin = 0;
    bit ended = 0;
    bit pv = 0;
    bit pr = 0;
    logic [63:0] pd = '0;
    logic [2:0]  pc = '0;
    logic [1:0]  pf = '0;
    logic [3:0]  pat = 4'b1001;
    for (int c = 0; c < 8; c++) begin
      if (msk[c]) begin
        for (int f = 0; f < 3; f++) begin
          ec[total] = c;
          ef[total] = f;
          total++;
        end
      end
    end
    for (int it = 0; it < 400 && !ended; it++) begin
      start = (it == restart_at);
      cfg_class_mask = start ? 8'h01 : msk;
      m_ready = (stall != 0) ? pat[it % 4] : 1'b1;
      abort = 1'b0;
      if (ab == 1) begin
        chk("abort_valid", m_valid, 0);
        chk("abort_busy", busy, 0);
        chk("abort_no_done", done, 0);
        chk("abort_last", m_last, 0);
        ended = 1;
      end else if (fin) begin
        chk("done_pulse", done, 1);
        chk("done_busy", busy, 0);
        chk("done_valid", m_valid, 0);
        chk("beat_count", k, total);
        if (exp_busy >= 0) chk("busy_cycles", busy_cnt, exp_busy);
        ended = 1;
      end else begin
        if (abort_after >= 0 && k == abort_after) begin
          abort = 1'b1;
          m_ready = 1'b0;
          ab = 1;
        end
        if (busy) busy_cnt++;
        chk("no_early_done", done, 0);
        if (it == 0) begin
          chk("first_valid_low", m_valid, 0);
          chk("busy_after_start", busy, 1);
        end
        if (it == 1) chk("first_valid_high", m_valid, 1);
        if (busy) begin
          chk("rom_idx_range", rom_frame_index < 2'd3, 1);
          chk("rom_id_enabled", msk[rom_frame_id], 1);
        end
        if (pv && !pr) begin
          chk("stall_valid", m_valid, 1);
          chk("stall_data", m_data, pd);
          chk("stall_cls", m_class_id, pc);
          chk("stall_frm", m_frame_index, pf);
        end
        if (m_valid && m_ready) begin
          chk("beat_cls", m_class_id, ec[k]);
          chk("beat_frm", m_frame_index, ef[k]);
          chk("beat_data", m_data, rom_f(3'(ec[k]), 2'(ef[k])));
          chk("beat_last_frame", m_last_frame, ef[k] == 2);
          chk("beat_last", m_last, k == total - 1);
          if (msk == 8'hFF && k == 0) chk("beat0_data", m_data, 64'h0003_007C_FE70_218C);
          if (msk == 8'hFF && k == 23) chk("beat23_data", m_data, 64'h9FF1_8781_E7FC_E0FF);
          k++;
          if (k == total) fin = 1;
        end
        pv = m_valid;
        pr = m_ready;
        pd = m_data;
        pc = m_class_id;
        pf = m_frame_index;
      end
      if (!ended) step();
    end
    start = 1'b0;
    abort = 1'b0;
    chk("sweep_end", ended, 1);
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    cfg_class_mask = 8'h00;
    m_ready = 1'b0;
    repeat (2) step();
    chk("rst_valid", m_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_last", m_last, 0);
    chk("rst_last_frame", m_last_frame, 0);
    chk("rst_data", m_data, 0);
    chk("rst_cls", m_class_id, 0);
    chk("rst_frm", m_frame_index, 0);
    chk("rst_rom_id", rom_frame_id, 0);
    chk("rst_rom_idx", rom_frame_index, 0);
    rst_n = 1'b1;
    step();

    // Full sweep, always ready.
    do_start(8'hFF);
    run(8'hFF, 0, -1, -1, 25);
    step();
    chk("done_one_cycle_a", done, 0);

    // Two sparse classes.
    do_start(8'b1000_0100);
    run(8'b1000_0100, 0, -1, -1, -1);
    step();
    chk("done_one_cycle_b", done, 0);

    // Backpressure pattern.
    do_start(8'hFF);
    run(8'hFF, 1, -1, -1, -1);
    step();
    chk("done_one_cycle_c", done, 0);

    // Empty mask.
    do_start(8'h00);
    chk("empty_done", done, 1);
    chk("empty_busy", busy, 0);
    chk("empty_valid", m_valid, 0);
    step();
    chk("empty_done_clear", done, 0);
    chk("empty_valid_later", m_valid, 0);

    // Abort after the 10th handshake, then a clean restart.
    do_start(8'hFF);
    run(8'hFF, 0, 10, -1, -1);
    repeat (2) begin
      step();
      chk("post_abort_done", done, 0);
      chk("post_abort_valid", m_valid, 0);
    end
    do_start(8'hFF);
    run(8'hFF, 0, -1, -1, 25);
    step();

    // Extra start while busy is ignored.
    do_start(8'hFF);
    run(8'hFF, 0, -1, 5, 25);
    step();

    // Reset mid-sweep clears outputs without a clock edge.
    do_start(8'hFF);
    m_ready = 1'b1;
    repeat (5) step();
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", m_valid, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_last", m_last, 0);
    chk("mid_rst_data", m_data, 0);
    chk("mid_rst_cls", m_class_id, 0);
    chk("mid_rst_rom_id", rom_frame_id, 0);
    chk("mid_rst_rom_idx", rom_frame_index, 0);
    step();
    rst_n = 1'b1;
    step();
    chk("after_rst_valid", m_valid, 0);
    chk("after_rst_done", done, 0);
    chk("after_rst_busy", busy, 0);
    do_start(8'b1000_0100);
    run(8'b1000_0100, 0, -1, -1, 7);
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
